ref_gate_mux: RTL and testbench

Registered reference-gate selector for the IC tester. It evaluates one two-input logic function (AND, OR, NAND, NOR, XOR, XNOR) on operands `a` and `b`, chosen by a 3-bit gate select. It returns the expected output bit for comparison against the device-under-test pin. The checker FSM uses this block as its golden model, sampling `y` once per input pattern.

---
 rtl/gate_mux_pkg.sv | 33 +++
 rtl/two_input_gate_bank.sv | 20 ++
 rtl/ref_gate_mux.sv | 66 ++++++
 tb/tb_ref_gate_mux.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/gate_mux_pkg.sv
// Shared constants for the reference-gate selector: select codes, truth tables
// (bit i = f(a=i[0], b=i[1])) and a select-to-truth-table lookup.
package gate_mux_pkg;

    localparam int GATE_SEL_W = 3;

    localparam logic [GATE_SEL_W-1:0] GATE_AND  = 3'd0;
    localparam logic [GATE_SEL_W-1:0] GATE_OR   = 3'd1;
    localparam logic [GATE_SEL_W-1:0] GATE_NAND = 3'd2;
    localparam logic [GATE_SEL_W-1:0] GATE_NOR  = 3'd3;
    localparam logic [GATE_SEL_W-1:0] GATE_XOR  = 3'd4;
    localparam logic [GATE_SEL_W-1:0] GATE_XNOR = 3'd5;

    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_NOR  = 4'b0001;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_XNOR = 4'b1001;

    function automatic logic [3:0] tt_of(input logic [GATE_SEL_W-1:0] sel);
        case (sel)
            GATE_AND:  return TT_AND;
            GATE_OR:   return TT_OR;
            GATE_NAND: return TT_NAND;
            GATE_NOR:  return TT_NOR;
            GATE_XOR:  return TT_XOR;
            GATE_XNOR: return TT_XNOR;
            default:   return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/two_input_gate_bank.sv
// Combinational bank of the six two-input reference gates.
module two_input_gate_bank (
    input  logic a,
    input  logic b,
    output logic y_and,
    output logic y_or,
    output logic y_nand,
    output logic y_nor,
    output logic y_xor,
    output logic y_xnor
);

    assign y_and  = a & b;
    assign y_or   = a | b;
    assign y_nand = ~(a & b);
    assign y_nor  = ~(a | b);
    assign y_xor  = a ^ b;
    assign y_xnor = ~(a ^ b);

endmodule

// File: rtl/ref_gate_mux.sv
// Registered reference-gate selector: one-cycle golden bit y for the pin checker.
// Optional GATE_MUX_TT_EN adds a registered 4-bit truth-table output tt.
module ref_gate_mux
    import gate_mux_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [GATE_SEL_W-1:0] sel,
    input  logic                  a,
    input  logic                  b,
    output logic                  y,
    output logic                  sel_err
`ifdef GATE_MUX_TT_EN
    ,
    output logic [3:0]            tt
`endif
);

    logic y_and, y_or, y_nand, y_nor, y_xor, y_xnor;
    logic y_nxt, err_nxt;

    two_input_gate_bank u_bank (
        .a      (a),
        .b      (b),
        .y_and  (y_and),
        .y_or   (y_or),
        .y_nand (y_nand),
        .y_nor  (y_nor),
        .y_xor  (y_xor),
        .y_xnor (y_xnor)
    );

    // Invalid selects force a 0 result so the checker never sees a stale gate.
    always_comb begin
        y_nxt   = 1'b0;
        err_nxt = 1'b0;
        case (sel)
            GATE_AND:  y_nxt = y_and;
            GATE_OR:   y_nxt = y_or;
            GATE_NAND: y_nxt = y_nand;
            GATE_NOR:  y_nxt = y_nor;
            GATE_XOR:  y_nxt = y_xor;
            GATE_XNOR: y_nxt = y_xnor;
            default:   err_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y       <= 1'b0;
            sel_err <= 1'b0;
        end else if (en) begin
            y       <= y_nxt;
            sel_err <= err_nxt;
        end
    end

`ifdef GATE_MUX_TT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  tt <= 4'b0000;
        else if (en) tt <= tt_of(sel);
    end
`endif

endmodule

// File: tb/tb_ref_gate_mux.sv
// Directed self-checking bench for ref_gate_mux; tt checks active with GATE_MUX_TT_EN.
module tb_ref_gate_mux;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [2:0] sel;
    logic       a, b;
    logic       y, sel_err;
`ifdef GATE_MUX_TT_EN
    logic [3:0] tt;
`endif

    int errors = 0;
    int checks = 0;

    // Hand-written truth tables, index = {b,a}, order AND OR NAND NOR XOR XNOR.
    localparam logic [3:0] EXP_TT [6] = '{4'b1000, 4'b1110, 4'b0111, 4'b0001, 4'b0110, 4'b1001};

    ref_gate_mux dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .sel     (sel),
        .a       (a),
        .b       (b),
        .y       (y),
        .sel_err (sel_err)
`ifdef GATE_MUX_TT_EN
        ,
        .tt      (tt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: got %b, want %b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] t;

        // Reset asserted with live inputs: outputs clear at once.
        en = 1'b1; sel = 3'd1; a = 1'b1; b = 1'b1;
        rst_n = 1'b0;
        #2;
        check("rst_y", {3'b0, y}, 4'd0);
        check("rst_err", {3'b0, sel_err}, 4'd0);
`ifdef GATE_MUX_TT_EN
        check("rst_tt", tt, 4'b0000);
`endif
        step();
        check("rst_hold_y", {3'b0, y}, 4'd0);
        rst_n = 1'b1;

        // Exhaustive sweep of valid selects.
        for (int s = 0; s < 6; s++) begin
            for (int ab = 0; ab < 4; ab++) begin
                sel = 3'(s);
                a = ab[0];
                b = ab[1];
                t = EXP_TT[s];
                step();
                check($sformatf("sweep_s%0d_b%0d_a%0d", s, b, a), {3'b0, y}, {3'b0, t[ab]});
                check("sweep_err", {3'b0, sel_err}, 4'd0);
            end
        end

        sel = 3'd2; a = 1'b1; b = 1'b1;
        step();
        check("nand_11", {3'b0, y}, 4'd0);

`ifdef GATE_MUX_TT_EN
        sel = 3'd4;
        step();
        check("tt_xor", tt, 4'b0110);
        sel = 3'd5;
        step();
        check("tt_xnor", tt, 4'b1001);
        sel = 3'd0;
        step();
        check("tt_and", tt, 4'b1000);
`endif

        // Invalid selects.
        sel = 3'd6; a = 1'b1; b = 1'b1;
        step();
        check("inv6_y", {3'b0, y}, 4'd0);
        check("inv6_err", {3'b0, sel_err}, 4'd1);
`ifdef GATE_MUX_TT_EN
        check("inv6_tt", tt, 4'b0000);
`endif
        sel = 3'd0;
        step();
        check("recov_y", {3'b0, y}, 4'd1);
        check("recov_err", {3'b0, sel_err}, 4'd0);
        sel = 3'd7; a = 1'b0; b = 1'b0;
        step();
        check("inv7_y", {3'b0, y}, 4'd0);
        check("inv7_err", {3'b0, sel_err}, 4'd1);

        // Hold with en low.
        sel = 3'd0; a = 1'b1; b = 1'b1;
        step();
        check("hold_pre_y", {3'b0, y}, 4'd1);
        en = 1'b0; a = 1'b0; sel = 3'd6;
        step();
        check("hold_y", {3'b0, y}, 4'd1);
        step();
        check("hold_y2", {3'b0, y}, 4'd1);
        check("hold_err", {3'b0, sel_err}, 4'd0);
        en = 1'b1; sel = 3'd0;
        step();
        check("reen_y", {3'b0, y}, 4'd0);

        // Select and operands change on the same edge.
        sel = 3'd2; a = 1'b1; b = 1'b1;
        step();
        check("coinc_pre", {3'b0, y}, 4'd0);
        sel = 3'd3; a = 1'b0; b = 1'b0;
        step();
        check("coinc_y", {3'b0, y}, 4'd1);

        // Mid-run asynchronous reset between edges.
        sel = 3'd0; a = 1'b1; b = 1'b1;
        step();
        check("mid_pre_y", {3'b0, y}, 4'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_y", {3'b0, y}, 4'd0);
        #1;
        rst_n = 1'b1;
        step();
        check("post_rst_y", {3'b0, y}, 4'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: bench did not finish, want finish before 50000");
        $fatal(1, "timeout");
    end

endmodule
